// File: rtl/pattern_shift_register.sv
// Parametrised pattern shift register: shift, rotate or parallel-load one position per step,
// with a modulo-WIDTH step counter, a wrap pulse and a random-access read port.
module pattern_shift_register #(
    parameter int WIDTH = 40,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             step,
    input  logic [1:0]       mode,
    input  logic             dir,
    input  logic             data_in,
    input  logic [WIDTH-1:0] load_data,
    input  logic [CNT_W-1:0] rd_idx,
    output logic [WIDTH-1:0] q,
    output logic             bit_out,
    output logic [CNT_W-1:0] shift_count,
    output logic             wrap,
    output logic             rd_bit
);

    localparam int EXT_W = 2 ** CNT_W;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] q_r;
    logic             bit_out_r;
    logic [CNT_W-1:0] count_r;
    logic             wrap_r;

    logic             in_bit_s;
    logic [WIDTH-1:0] moved_q_s;
    logic             moved_bit_s;
    logic [EXT_W-1:0] q_ext_s;

    // Next pattern and ejected bit for a shift or rotate in the selected direction
    always_comb begin
        in_bit_s    = data_in;
        moved_q_s   = q_r;
        moved_bit_s = 1'b0;
        if (dir == 1'b0) begin
            if (mode == 2'b10) begin
                in_bit_s = q_r[WIDTH-1];
            end else begin
                in_bit_s = data_in;
            end
            moved_q_s   = {q_r[WIDTH-2:0], in_bit_s};
            moved_bit_s = q_r[WIDTH-1];
        end else begin
            if (mode == 2'b10) begin
                in_bit_s = q_r[0];
            end else begin
                in_bit_s = data_in;
            end
            moved_q_s   = {in_bit_s, q_r[WIDTH-1:1]};
            moved_bit_s = q_r[0];
        end
    end

    // Pattern, ejected bit, step counter and wrap pulse; reset beats any step
    always_ff @(posedge clk) begin
        if (!resetn) begin
            q_r       <= '0;
            bit_out_r <= 1'b0;
            count_r   <= '0;
            wrap_r    <= 1'b0;
        end else begin
            wrap_r <= 1'b0;
            if (step) begin
                case (mode)
                    2'b01, 2'b10: begin
                        q_r       <= moved_q_s;
                        bit_out_r <= moved_bit_s;
                        if (count_r == LAST_CNT) begin
                            count_r <= '0;
                            wrap_r  <= 1'b1;
                        end else begin
                            count_r <= count_r + CNT_W'(1);
                        end
                    end
                    2'b11: begin
                        q_r       <= load_data;
                        bit_out_r <= 1'b0;
                        count_r   <= '0;
                    end
                    default: begin
                        q_r       <= q_r;
                        bit_out_r <= bit_out_r;
                        count_r   <= count_r;
                    end
                endcase
            end else begin
                q_r       <= q_r;
                bit_out_r <= bit_out_r;
                count_r   <= count_r;
            end
        end
    end

    // Zero-padding q to the full index range makes out-of-range reads return 0
    assign q_ext_s = {{(EXT_W - WIDTH){1'b0}}, q_r};
    assign rd_bit  = q_ext_s[rd_idx];

    assign q           = q_r;
    assign bit_out     = bit_out_r;
    assign shift_count = count_r;
    assign wrap        = wrap_r;

endmodule

// File: tb/tb_pattern_shift_register.sv
// Directed bench for pattern_shift_register: a 40-bit instance for the main scenarios
// and an 8-bit instance for shift-right and read-port range behaviour.
module tb_pattern_shift_register;

    logic        clk;
    logic        resetn;

    logic        step_a, dir_a, data_in_a;
    logic [1:0]  mode_a;
    logic [39:0] load_a;
    logic [5:0]  rd_idx_a;
    logic [39:0] q_a;
    logic        bit_out_a, wrap_a, rd_bit_a;
    logic [5:0]  count_a;

    logic        step_b, dir_b, data_in_b;
    logic [1:0]  mode_b;
    logic [7:0]  load_b;
    logic [3:0]  rd_idx_b;
    logic [7:0]  q_b;
    logic        bit_out_b, wrap_b, rd_bit_b;
    logic [3:0]  count_b;

    int tests_run    = 0;
    int tests_failed = 0;

    pattern_shift_register #(.WIDTH(40), .CNT_W(6)) dut_a (
        .clk(clk), .resetn(resetn), .step(step_a), .mode(mode_a), .dir(dir_a),
        .data_in(data_in_a), .load_data(load_a), .rd_idx(rd_idx_a), .q(q_a),
        .bit_out(bit_out_a), .shift_count(count_a), .wrap(wrap_a), .rd_bit(rd_bit_a)
    );

    pattern_shift_register #(.WIDTH(8), .CNT_W(4)) dut_b (
        .clk(clk), .resetn(resetn), .step(step_b), .mode(mode_b), .dir(dir_b),
        .data_in(data_in_b), .load_data(load_b), .rd_idx(rd_idx_b), .q(q_b),
        .bit_out(bit_out_b), .shift_count(count_b), .wrap(wrap_b), .rd_bit(rd_bit_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run = tests_run + 1;
        if (got !== exp) begin
            tests_failed = tests_failed + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [39:0] exp_q;
    int          wrap_seen;

    initial begin
        resetn = 1'b0;
        step_a = 1'b1; mode_a = 2'b11; dir_a = 1'b0; data_in_a = 1'b0;
        load_a = {40{1'b1}}; rd_idx_a = 6'd0;
        step_b = 1'b1; mode_b = 2'b11; dir_b = 1'b0; data_in_b = 1'b0;
        load_b = 8'hFF; rd_idx_b = 4'd0;
        tick();
        tick();
        check("rst_q", q_a, 64'h0);
        check("rst_bit_out", bit_out_a, 64'h0);
        check("rst_count", count_a, 64'h0);
        check("rst_wrap", wrap_a, 64'h0);
        check("rst_q8", q_b, 64'h0);

        // Load, then four shift-left steps with data_in=1
        resetn = 1'b1;
        load_a = 40'hF0_0000_000F;
        load_b = 8'h81;
        tick();
        check("load_q", q_a, 64'hF0_0000_000F);
        check("load_count", count_a, 64'h0);
        check("load_q8", q_b, 64'h81);

        // Narrow instance: one shift-right step with data_in=0
        mode_b = 2'b01; dir_b = 1'b1; data_in_b = 1'b0;
        mode_a = 2'b01; dir_a = 1'b0; data_in_a = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            step_b = 1'b0;
            check($sformatf("shl_bit_out_%0d", i), bit_out_a, 64'h1);
            check($sformatf("shl_count_%0d", i), count_a, 64'(i));
        end
        check("shl_q", q_a, 64'h00_0000_00FF);
        check("shr_q8", q_b, 64'h40);
        check("shr_bit_out8", bit_out_b, 64'h1);
        check("shr_count8", count_b, 64'h1);
        rd_idx_b = 4'd6; #1;
        check("rd8_idx6", rd_bit_b, 64'h1);
        rd_idx_b = 4'd7; #1;
        check("rd8_idx7", rd_bit_b, 64'h0);
        rd_idx_b = 4'd9; #1;
        check("rd8_idx9", rd_bit_b, 64'h0);
        rd_idx_a = 6'd7; #1;
        check("rd40_idx7", rd_bit_a, 64'h1);
        rd_idx_a = 6'd8; #1;
        check("rd40_idx8", rd_bit_a, 64'h0);

        // Idle: step low with shift selected and data_in toggling
        step_a = 1'b0;
        for (int i = 0; i < 10; i++) begin
            data_in_a = i[0];
            tick();
            check($sformatf("idle_q_%0d", i), q_a, 64'h00_0000_00FF);
            check($sformatf("idle_wrap_%0d", i), wrap_a, 64'h0);
        end
        check("idle_count", count_a, 64'h4);
        check("idle_bit_out", bit_out_a, 64'h1);

        // Full rotation: 40 rotate-left steps of a single set bit
        step_a = 1'b1; mode_a = 2'b11; load_a = 40'h1;
        tick();
        check("rot_load_bit_out", bit_out_a, 64'h0);
        mode_a = 2'b10; dir_a = 1'b0;
        exp_q = 40'h1;
        wrap_seen = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            exp_q = {exp_q[38:0], exp_q[39]};
            check($sformatf("rot_q_%0d", i), q_a, 64'(exp_q));
            check($sformatf("rot_wrap_%0d", i), wrap_a, (i == 40) ? 64'h1 : 64'h0);
            if (wrap_a) wrap_seen = wrap_seen + 1;
        end
        check("rot_q_final", q_a, 64'h1);
        check("rot_count_final", count_a, 64'h0);
        check("rot_bit_out", bit_out_a, 64'h1);
        step_a = 1'b0;
        tick();
        check("rot_wrap_after", wrap_a, 64'h0);
        check("rot_wrap_count", 64'(wrap_seen), 64'h1);

        // Rotate right pushes the LSB into the MSB
        step_a = 1'b1; dir_a = 1'b1;
        tick();
        check("ror_q", q_a, 64'h80_0000_0000);
        check("ror_bit_out", bit_out_a, 64'h1);
        check("ror_count", count_a, 64'h1);
        // Shift right with data_in=1 after a direction change keeps counting
        mode_a = 2'b01; data_in_a = 1'b1;
        tick();
        check("shr_q", q_a, 64'hC0_0000_0000);
        check("shr_bit_out", bit_out_a, 64'h0);
        check("shr_count", count_a, 64'h2);

        // Reset mid-operation with count at 39
        mode_a = 2'b11; load_a = 40'h1;
        tick();
        mode_a = 2'b10; dir_a = 1'b0;
        for (int i = 0; i < 39; i++) tick();
        check("pre_rst_count", count_a, 64'd39);
        resetn = 1'b0;
        tick();
        check("mid_rst_count", count_a, 64'h0);
        check("mid_rst_wrap", wrap_a, 64'h0);
        check("mid_rst_q", q_a, 64'h0);
        check("mid_rst_bit_out", bit_out_a, 64'h0);
        resetn = 1'b1; step_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("post_rst_wrap_%0d", i), wrap_a, 64'h0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
